// File: rtl/ser_pkg.sv
// Shared definitions for the bit-serial datapath: FSM states, default word
// width and the bit-counter width helper.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned SER_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lsb_serializer.sv
// LSB-first parallel-to-serial converter with valid/ready on both sides.
// Optional SER_PARITY_EN appends an even-parity bit after the data bits.
module lsb_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             word_start,
    output logic             word_last
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef SER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    ser_state_t       state, state_nxt;
    logic [FRAME-1:0] sreg;
    logic [FRAME-1:0] frame_d;
    logic [CW-1:0]    cnt;
    logic             xfer;
    logic             is_last;
    logic             load_fire;

    // Parity rides as the top bit of the shift register so it falls out at index WIDTH.
    always_comb begin
`ifdef SER_PARITY_EN
        frame_d = {^load_data, load_data};
`else
        frame_d = load_data;
`endif
    end

    always_comb begin
        bit_valid  = (state == SHIFT);
        xfer       = bit_valid & bit_ready;
        is_last    = (cnt == LAST_IDX);
        word_start = bit_valid & (cnt == '0);
        word_last  = bit_valid & is_last;
        bit_out    = bit_valid & sreg[0];
        load_ready = (state == IDLE) | (xfer & word_last);
        load_fire  = load_valid & load_ready;

        state_nxt = state;
        if (load_fire) begin
            state_nxt = SHIFT;
        end else if (xfer && is_last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load_fire) begin
                sreg <= frame_d;
                cnt  <= '0;
            end else if (xfer) begin
                sreg <= sreg >> 1;
                cnt  <= is_last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsb_serializer.sv
// Directed self-checking bench for lsb_serializer (WIDTH=8); honours SER_PARITY_EN.
module tb_lsb_serializer;

    localparam int unsigned WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned FRAME = 9;
    localparam logic [15:0] EXP_16 = 16'h0116;
    localparam logic [15:0] EXP_03 = 16'h0003;
    localparam logic [15:0] EXP_FF = 16'h00FF;
    localparam logic [15:0] EXP_01 = 16'h0101;
    localparam logic [15:0] EXP_80 = 16'h0180;
`else
    localparam int unsigned FRAME = 8;
    localparam logic [15:0] EXP_16 = 16'h0016;
    localparam logic [15:0] EXP_03 = 16'h0003;
    localparam logic [15:0] EXP_FF = 16'h00FF;
    localparam logic [15:0] EXP_01 = 16'h0001;
    localparam logic [15:0] EXP_80 = 16'h0080;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             word_start;
    logic             word_last;

    int checks = 0;
    int errors = 0;

    lsb_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .word_start (word_start),
        .word_last  (word_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled at the falling edge; inputs change there too.
    task automatic bit_check(input string tag, input logic [15:0] frame, input int unsigned idx);
        logic [15:0] f;
        f = frame;
        chk({tag, " valid"}, 32'(bit_valid), 32'd1);
        chk({tag, " bit"},   32'(bit_out), 32'(f[idx]));
        chk({tag, " start"}, 32'(word_start), 32'(idx == 0));
        chk({tag, " last"},  32'(word_last), 32'(idx == FRAME - 1));
    endtask

    task automatic run_word(input string tag, input logic [7:0] data, input logic [15:0] frame);
        load_valid = 1'b1;
        load_data  = data;
        bit_ready  = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int unsigned i = 0; i < FRAME; i++) begin
            bit_check(tag, frame, i);
            @(negedge clk);
        end
        chk({tag, " idle valid"}, 32'(bit_valid), 32'd0);
        chk({tag, " idle ready"}, 32'(load_ready), 32'd1);
        chk({tag, " idle bit"},   32'(bit_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hA5;
        bit_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst valid", 32'(bit_valid), 32'd0);
        chk("rst bit",   32'(bit_out), 32'd0);
        chk("rst ready", 32'(load_ready), 32'd1);
        chk("rst start", 32'(word_start), 32'd0);
        chk("rst last",  32'(word_last), 32'd0);
        rst        = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        chk("post rst no capture", 32'(bit_valid), 32'd0);

        run_word("w16", 8'h16, EXP_16);
        run_word("w03", 8'h03, EXP_03);

        // Backpressure: index 3 held for cycles 4..7, final bit lands in cycle FRAME+3.
        load_valid = 1'b1;
        load_data  = 8'h16;
        @(negedge clk);
        load_valid = 1'b0;
        for (int unsigned c = 1; c <= FRAME + 3; c++) begin
            int unsigned idx;
            idx = (c <= 3) ? c - 1 : (c <= 7) ? 3 : c - 4;
            bit_check("bp", EXP_16, idx);
            bit_ready = !(c >= 4 && c <= 6);
            @(negedge clk);
        end
        chk("bp end valid", 32'(bit_valid), 32'd0);

        // Back-to-back: second word pending while the first shifts out.
        bit_ready  = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(negedge clk);
        load_data  = 8'h01;
        for (int unsigned i = 0; i < FRAME; i++) begin
            bit_check("b2b a", EXP_FF, i);
            chk("b2b a ready", 32'(load_ready), 32'(i == FRAME - 1));
            @(negedge clk);
        end
        load_valid = 1'b0;
        for (int unsigned i = 0; i < FRAME; i++) begin
            bit_check("b2b b", EXP_01, i);
            @(negedge clk);
        end
        chk("b2b end valid", 32'(bit_valid), 32'd0);

        // Mid-word reset after four bits.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            bit_check("mrst", EXP_FF, i);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mrst valid", 32'(bit_valid), 32'd0);
        chk("mrst ready", 32'(load_ready), 32'd1);
        chk("mrst bit",   32'(bit_out), 32'd0);
        @(negedge clk);
        chk("mrst no resume", 32'(bit_valid), 32'd0);
        run_word("w80", 8'h80, EXP_80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
